// File: rtl/stream_scheduler_if.sv
// Port bundle for stream_scheduler: channel programming, per-channel word streams,
// the idle-slot memory request port toward mem_control, and channel status.
interface stream_scheduler_if #(
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int CHANNELS        = 4,
    parameter int LEN_WIDTH       = 16
);
    localparam int CH_WIDTH = $clog2(CHANNELS);

    // Core arbitration
    logic                           core_mem_busy;

    // Channel programming (valid/ready)
    logic                           cfg_valid;
    logic                           cfg_ready;
    logic [CH_WIDTH-1:0]            cfg_channel;
    logic                           cfg_dir;
    logic [MAIN_ADDR_WIDTH-1:0]     cfg_address;
    logic [LEN_WIDTH-1:0]           cfg_length;

    // Per-channel word streams
    logic [CHANNELS-1:0]            ch_in_valid;
    logic [CHANNELS*WORD_WIDTH-1:0] ch_in_data;
    logic [CHANNELS-1:0]            ch_in_ready;
    logic [CHANNELS-1:0]            ch_out_valid;
    logic [CHANNELS*WORD_WIDTH-1:0] ch_out_data;
    logic [CHANNELS-1:0]            ch_out_ready;

    // Memory port toward mem_control
    logic [WORD_WIDTH-1:0]          mem_read_value;
    logic                           stream_in;
    logic                           stream_out;
    logic [MAIN_ADDR_WIDTH-1:0]     stream_address;
    logic [WORD_WIDTH-1:0]          stream_in_value;

    // Status and debug (2 bits of channel FSM state per channel)
    logic [CHANNELS-1:0]            ch_busy;
    logic [CHANNELS-1:0]            ch_done;
    logic [2*CHANNELS-1:0]          ch_state;

    modport master (
        output core_mem_busy, cfg_valid, cfg_channel, cfg_dir, cfg_address, cfg_length,
               ch_in_valid, ch_in_data, ch_out_ready, mem_read_value,
        input  cfg_ready, ch_in_ready, ch_out_valid, ch_out_data,
               stream_in, stream_out, stream_address, stream_in_value,
               ch_busy, ch_done, ch_state
    );

    modport slave (
        input  core_mem_busy, cfg_valid, cfg_channel, cfg_dir, cfg_address, cfg_length,
               ch_in_valid, ch_in_data, ch_out_ready, mem_read_value,
        output cfg_ready, ch_in_ready, ch_out_valid, ch_out_data,
               stream_in, stream_out, stream_address, stream_in_value,
               ch_busy, ch_done, ch_state
    );
endinterface

// File: rtl/stream_scheduler.sv
// Round-robin block-stream sequencer that borrows idle memory-port cycles from the core
// to move words between CHANNELS external streams and main memory.
module stream_scheduler #(
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int CHANNELS        = 4,
    parameter int LEN_WIDTH       = 16
) (
    input logic               clk,
    input logic               reset,
    stream_scheduler_if.slave bus
);
    localparam int CW = $clog2(CHANNELS);

    // All handshakes (cfg, ch_in, ch_out) are valid/ready: a transfer happens in the
    // cycle both are high; valid never waits on ready, and ready may depend on valid.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IN   = 2'd1,
        ST_OUT  = 2'd2
    } ch_state_e;

    ch_state_e                  state_q [CHANNELS];
    ch_state_e                  state_d [CHANNELS];
    logic [MAIN_ADDR_WIDTH-1:0] addr_q  [CHANNELS];
    logic [MAIN_ADDR_WIDTH-1:0] addr_d  [CHANNELS];
    logic [LEN_WIDTH-1:0]       rem_q   [CHANNELS];
    logic [LEN_WIDTH-1:0]       rem_d   [CHANNELS];
    logic [WORD_WIDTH-1:0]      obuf_q  [CHANNELS];
    logic [WORD_WIDTH-1:0]      obuf_d  [CHANNELS];

    logic [CHANNELS-1:0]        obuf_valid_q, obuf_valid_d;
    logic [CHANNELS-1:0]        rd_pend_q, rd_pend_d;
    logic [CHANNELS-1:0]        done_q, done_d;
    logic [CW-1:0]              rr_q, rr_d;

    logic [CHANNELS-1:0]        eligible;
    logic                       grant_valid;
    logic [CW-1:0]              grant_idx;
    logic [CW-1:0]              scan_idx;
    logic                       cfg_fire;

    logic                       stream_in_c;
    logic                       stream_out_c;
    logic [MAIN_ADDR_WIDTH-1:0] stream_address_c;
    logic [WORD_WIDTH-1:0]      stream_in_value_c;
    logic [CHANNELS-1:0]        in_ready_c;
    logic [CHANNELS*WORD_WIDTH-1:0] out_data_c;
    logic [CHANNELS-1:0]        busy_c;
    logic [2*CHANNELS-1:0]      state_vec_c;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                addr_q[c]  <= '0;
                rem_q[c]   <= '0;
                obuf_q[c]  <= '0;
            end
            obuf_valid_q <= '0;
            rd_pend_q    <= '0;
            done_q       <= '0;
            rr_q         <= CW'(CHANNELS - 1);
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            obuf_q       <= obuf_d;
            obuf_valid_q <= obuf_valid_d;
            rd_pend_q    <= rd_pend_d;
            done_q       <= done_d;
            rr_q         <= rr_d;
        end
    end

    // ------------------------------------------------------------------
    // Eligibility and round-robin grant
    // ------------------------------------------------------------------
    always_comb begin
        eligible = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            eligible[c] = ((state_q[c] == ST_IN) && bus.ch_in_valid[c] && (rem_q[c] != '0)) ||
                          ((state_q[c] == ST_OUT) && (rem_q[c] != '0) &&
                           !obuf_valid_q[c] && !rd_pend_q[c]);
        end
    end

    // Scan rr+1 .. rr+CHANNELS; the last candidate wraps back to the pointer itself.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (!reset && !bus.core_mem_busy) begin
            for (int i = 1; i <= CHANNELS; i++) begin
                scan_idx = rr_q + CW'(i);
                if (!grant_valid && eligible[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory-port request for the granted channel
    // ------------------------------------------------------------------
    always_comb begin
        stream_in_c       = 1'b0;
        stream_out_c      = 1'b0;
        stream_address_c  = '0;
        stream_in_value_c = '0;
        in_ready_c        = '0;
        if (grant_valid) begin
            stream_address_c = addr_q[grant_idx];
            if (state_q[grant_idx] == ST_IN) begin
                stream_in_c           = 1'b1;
                in_ready_c[grant_idx] = 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (grant_idx == CW'(c)) begin
                        stream_in_value_c = bus.ch_in_data[c*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
            end else begin
                stream_out_c = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel next state
    // ------------------------------------------------------------------
    assign cfg_fire = bus.cfg_valid && bus.cfg_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        obuf_d       = obuf_q;
        obuf_valid_d = obuf_valid_q;
        rd_pend_d    = rd_pend_q;
        done_d       = '0;
        rr_d         = rr_q;

        for (int c = 0; c < CHANNELS; c++) begin
            // Read data lands exactly one cycle after the stream_out issue.
            if (rd_pend_q[c]) begin
                obuf_d[c]       = bus.mem_read_value;
                obuf_valid_d[c] = 1'b1;
                rd_pend_d[c]    = 1'b0;
            end
            if (obuf_valid_q[c] && bus.ch_out_ready[c]) begin
                obuf_valid_d[c] = 1'b0;
                if (rem_q[c] == '0) begin
                    state_d[c] = ST_IDLE;
                    done_d[c]  = 1'b1;
                end
            end
        end

        if (grant_valid) begin
            rr_d             = grant_idx;
            addr_d[grant_idx] = addr_q[grant_idx] + MAIN_ADDR_WIDTH'(1);
            rem_d[grant_idx]  = rem_q[grant_idx] - LEN_WIDTH'(1);
            if (state_q[grant_idx] == ST_IN) begin
                if (rem_q[grant_idx] == LEN_WIDTH'(1)) begin
                    state_d[grant_idx] = ST_IDLE;
                    done_d[grant_idx]  = 1'b1;
                end
            end else begin
                rd_pend_d[grant_idx] = 1'b1;
            end
        end

        // Only an IDLE channel accepts a program, so this never collides with the above.
        if (cfg_fire) begin
            addr_d[bus.cfg_channel] = bus.cfg_address;
            rem_d[bus.cfg_channel]  = bus.cfg_length;
            if (bus.cfg_length == '0) begin
                done_d[bus.cfg_channel] = 1'b1;
            end else begin
                state_d[bus.cfg_channel] = bus.cfg_dir ? ST_OUT : ST_IN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status and outbound data
    // ------------------------------------------------------------------
    always_comb begin
        out_data_c  = '0;
        busy_c      = '0;
        state_vec_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_data_c[c*WORD_WIDTH +: WORD_WIDTH] = obuf_q[c];
            busy_c[c]                              = (state_q[c] != ST_IDLE);
            state_vec_c[2*c +: 2]                  = state_q[c];
        end
    end

    assign bus.cfg_ready       = !reset && (state_q[bus.cfg_channel] == ST_IDLE);
    assign bus.ch_in_ready     = in_ready_c;
    assign bus.ch_out_valid    = obuf_valid_q;
    assign bus.ch_out_data     = out_data_c;
    assign bus.stream_in       = stream_in_c;
    assign bus.stream_out      = stream_out_c;
    assign bus.stream_address  = stream_address_c;
    assign bus.stream_in_value = stream_in_value_c;
    assign bus.ch_busy         = busy_c;
    assign bus.ch_done         = done_q;
    assign bus.ch_state        = state_vec_c;

`ifndef SYNTHESIS
    a_rw_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(bus.stream_in && bus.stream_out));
    a_core_priority : assert property (@(posedge clk) disable iff (reset)
        bus.core_mem_busy |-> !(bus.stream_in || bus.stream_out || (|bus.ch_in_ready)));
`endif

endmodule

// File: tb/tb_stream_scheduler.sv
// Self-checking bench for stream_scheduler: scoreboard queues for memory writes, reads
// and outbound words, plus direct checks of reset, priority and edge behaviour.
module tb_stream_scheduler;
    localparam int A  = 16;
    localparam int W  = 32;
    localparam int CH = 4;
    localparam int L  = 16;
    localparam int CW = 2;

    logic clk;
    logic reset;

    stream_scheduler_if #(.MAIN_ADDR_WIDTH(A), .WORD_WIDTH(W), .CHANNELS(CH), .LEN_WIDTH(L)) bus ();

    stream_scheduler #(.MAIN_ADDR_WIDTH(A), .WORD_WIDTH(W), .CHANNELS(CH), .LEN_WIDTH(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [A+W-1:0]  exp_wr_q [$];
    logic [A-1:0]    exp_rd_q [$];
    logic [CW+W-1:0] exp_out_q [$];
    logic [W-1:0]    mem_model [int];
    int              done_cnt [CH];
    int              n_checks;
    int              n_pass;
    int              s0, s3, d;
    logic [A+W-1:0]  wr_e;
    logic [CW+W-1:0] out_e;
    logic [A-1:0]    rd_e;
    logic [A-1:0]    rsp_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks (enter and leave at posedge+1) ----------------
    task automatic program_ch(input int ch, input logic dir, input logic [A-1:0] addr,
                              input logic [L-1:0] len);
        logic [31:0] chv;
        chv             = ch;
        bus.cfg_valid   = 1'b1;
        bus.cfg_channel = chv[CW-1:0];
        bus.cfg_dir     = dir;
        bus.cfg_address = addr;
        bus.cfg_length  = len;
        @(negedge clk);
        check_val("cfg_ready", bus.cfg_ready, 1);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic drive_in(input int ch, input logic [W-1:0] base, input int n, output int stalls);
        logic got;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            bus.ch_in_valid[ch]         = 1'b1;
            bus.ch_in_data[ch*W +: W]   = base + W'(k);
            got = 1'b0;
            for (int t = 0; t < 64 && !got; t++) begin
                @(negedge clk);
                if (bus.ch_in_ready[ch]) got = 1'b1;
                else stalls++;
            end
            check_val("in_accept", got, 1);
            @(posedge clk); #1;
        end
        bus.ch_in_valid[ch] = 1'b0;
    endtask

    // ---------------- memory responder: data valid the cycle after stream_out ----------------
    initial begin
        bus.mem_read_value = '0;
        forever begin
            @(negedge clk);
            if (bus.stream_out) begin
                rsp_addr = bus.stream_address;
                @(posedge clk); #1;
                bus.mem_read_value = mem_model.exists(int'(rsp_addr)) ? mem_model[int'(rsp_addr)]
                                                                     : {16'hDEAD, rsp_addr};
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        for (int c = 0; c < CH; c++) done_cnt[c] = 0;
        forever begin
            @(negedge clk);
            if (bus.stream_in) begin
                check_val("wr_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) begin
                    wr_e = exp_wr_q.pop_front();
                    check_val("wr_addr", bus.stream_address, wr_e[W +: A]);
                    check_val("wr_data", bus.stream_in_value, wr_e[W-1:0]);
                end
                check_val("rw_exclusive", bus.stream_out, 0);
            end
            if (bus.stream_out) begin
                check_val("rd_expected", exp_rd_q.size() != 0, 1);
                if (exp_rd_q.size() != 0) begin
                    rd_e = exp_rd_q.pop_front();
                    check_val("rd_addr", bus.stream_address, rd_e);
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (bus.ch_done[c]) done_cnt[c]++;
                if (bus.ch_out_valid[c] && bus.ch_out_ready[c]) begin
                    check_val("out_expected", exp_out_q.size() != 0, 1);
                    if (exp_out_q.size() != 0) begin
                        out_e = exp_out_q.pop_front();
                        check_val("out_channel", c, out_e[W +: CW]);
                        check_val("out_data", bus.ch_out_data[c*W +: W], out_e[W-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset             = 1'b1;
        bus.core_mem_busy = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_channel   = '0;
        bus.cfg_dir       = 1'b0;
        bus.cfg_address   = '0;
        bus.cfg_length    = '0;
        bus.ch_in_valid   = '0;
        bus.ch_in_data    = '0;
        bus.ch_out_ready  = '0;
        mem_model[32'h0200] = 32'h0000_0011;
        mem_model[32'h0201] = 32'h0000_0022;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_cfg_ready", bus.cfg_ready, 0);
        check_val("rst_busy", bus.ch_busy, 0);
        check_val("rst_done", bus.ch_done, 0);
        check_val("rst_stream_in", bus.stream_in, 0);
        check_val("rst_stream_out", bus.stream_out, 0);
        check_val("rst_address", bus.stream_address, 0);
        check_val("rst_out_valid", bus.ch_out_valid, 0);
        check_val("rst_state", bus.ch_state, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("cfg_ready_post_rst", bus.cfg_ready, 1);
        @(posedge clk); #1;

        // Round-robin: ch0 and ch3 both valid, expect 0,3,0,3
        program_ch(0, 1'b0, 16'h0300, 16'd2);
        program_ch(3, 1'b0, 16'h0400, 16'd2);
        exp_wr_q.push_back({16'h0300, 32'h30});
        exp_wr_q.push_back({16'h0400, 32'h40});
        exp_wr_q.push_back({16'h0301, 32'h31});
        exp_wr_q.push_back({16'h0401, 32'h41});
        fork
            drive_in(0, 32'h30, 2, s0);
            drive_in(3, 32'h40, 2, s3);
        join
        check_val("rr_stalls_ch0", s0, 1);
        check_val("rr_stalls_ch3", s3, 2);
        repeat (2) @(posedge clk); #1;
        check_val("rr_done_ch0", done_cnt[0], 1);
        check_val("rr_done_ch3", done_cnt[3], 1);
        check_val("rr_wr_drained", exp_wr_q.size(), 0);

        // Inbound: ch1, 3 words on consecutive cycles
        exp_wr_q.push_back({16'h0100, 32'hA});
        exp_wr_q.push_back({16'h0101, 32'hB});
        exp_wr_q.push_back({16'h0102, 32'hC});
        d = done_cnt[1];
        program_ch(1, 1'b0, 16'h0100, 16'd3);
        drive_in(1, 32'hA, 3, s0);
        check_val("in_consecutive", s0, 0);
        repeat (2) @(posedge clk); #1;
        check_val("in_done_once", done_cnt[1] - d, 1);
        check_val("in_not_busy", bus.ch_busy[1], 0);

        // Outbound: ch2, second read waits for the first handshake
        exp_rd_q.push_back(16'h0200);
        exp_rd_q.push_back(16'h0201);
        exp_out_q.push_back({2'd2, 32'h11});
        exp_out_q.push_back({2'd2, 32'h22});
        d = done_cnt[2];
        program_ch(2, 1'b1, 16'h0200, 16'd2);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_val("out_second_read_held", exp_rd_q.size(), 1);
        check_val("out_valid_held", bus.ch_out_valid[2], 1);
        check_val("out_data_held", bus.ch_out_data[2*W +: W], 32'h11);
        check_val("out_busy", bus.ch_busy[2], 1);
        @(posedge clk); #1;
        bus.ch_out_ready[2] = 1'b1;
        for (int k = 0; k < 40 && done_cnt[2] == d; k++) @(posedge clk);
        #1;
        bus.ch_out_ready[2] = 1'b0;
        check_val("out_done_once", done_cnt[2] - d, 1);
        check_val("out_rd_drained", exp_rd_q.size(), 0);
        check_val("out_words_drained", exp_out_q.size(), 0);
        @(negedge clk);
        check_val("out_not_busy", bus.ch_busy[2], 0);
        @(posedge clk); #1;

        // Core priority: 4 busy cycles, grant on the first free cycle
        bus.core_mem_busy            = 1'b1;
        bus.ch_in_valid[0]           = 1'b1;
        bus.ch_in_data[0*W +: W]     = 32'h55;
        exp_wr_q.push_back({16'h0500, 32'h55});
        d = done_cnt[0];
        program_ch(0, 1'b0, 16'h0500, 16'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("busy_no_write", bus.stream_in, 0);
            check_val("busy_no_ready", bus.ch_in_ready[0], 0);
            check_val("busy_addr_zero", bus.stream_address, 0);
            @(posedge clk); #1;
        end
        bus.core_mem_busy = 1'b0;
        @(negedge clk);
        check_val("grant_after_busy", bus.ch_in_ready[0], 1);
        @(posedge clk); #1;
        bus.ch_in_valid[0] = 1'b0;
        repeat (2) @(posedge clk); #1;
        check_val("busy_done_once", done_cnt[0] - d, 1);

        // Address wrap
        exp_wr_q.push_back({16'hFFFF, 32'hF0});
        exp_wr_q.push_back({16'h0000, 32'hF1});
        d = done_cnt[3];
        program_ch(3, 1'b0, 16'hFFFF, 16'd2);
        drive_in(3, 32'hF0, 2, s3);
        repeat (2) @(posedge clk); #1;
        check_val("wrap_done", done_cnt[3] - d, 1);
        check_val("wrap_drained", exp_wr_q.size(), 0);

        // Zero length: done next cycle, never busy
        d = done_cnt[2];
        program_ch(2, 1'b1, 16'h1234, 16'd0);
        @(negedge clk);
        check_val("len0_done_pulse", bus.ch_done[2], 1);
        check_val("len0_not_busy", bus.ch_busy[2], 0);
        repeat (3) @(posedge clk); #1;
        check_val("len0_done_once", done_cnt[2] - d, 1);

        // Busy channel rejects cfg; then reset after 1 of 4 words
        program_ch(1, 1'b0, 16'h0700, 16'd4);
        bus.cfg_valid   = 1'b1;
        bus.cfg_channel = 2'd1;
        bus.cfg_dir     = 1'b1;
        bus.cfg_address = 16'h0800;
        bus.cfg_length  = 16'd9;
        @(negedge clk);
        check_val("cfg_busy_ready", bus.cfg_ready, 0);
        check_val("cfg_busy_state", bus.ch_busy[1], 1);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        exp_wr_q.push_back({16'h0700, 32'h70});
        d = done_cnt[1];
        drive_in(1, 32'h70, 1, s0);
        bus.ch_in_valid[1] = 1'b1;
        reset = 1'b1;
        #1;
        check_val("mid_rst_cfg_ready", bus.cfg_ready, 0);
        check_val("mid_rst_busy", bus.ch_busy, 0);
        check_val("mid_rst_in_ready", bus.ch_in_ready, 0);
        check_val("mid_rst_stream_in", bus.stream_in, 0);
        check_val("mid_rst_address", bus.stream_address, 0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_cfg_ready", bus.cfg_ready, 1);
        check_val("post_rst_busy", bus.ch_busy, 0);
        check_val("post_rst_in_ready", bus.ch_in_ready[1], 0);
        @(posedge clk); #1;
        bus.ch_in_valid[1] = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_val("rst_no_done", done_cnt[1] - d, 0);

        // Final drain
        check_val("final_wr_empty", exp_wr_q.size(), 0);
        check_val("final_rd_empty", exp_rd_q.size(), 0);
        check_val("final_out_empty", exp_out_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
